// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared defaults, opcodes and FSM state types for the PE array
package pe_array_pkg;

    localparam int PE_ARRAY_NUM_OF_PE_DEF   = 4;
    localparam int PE_NUM_OF_EXEC_LANES_DEF = 4;
    localparam int DATA_W_DEF               = 32;
    localparam int ADDR_W_DEF               = 16;

    localparam logic [3:0] OP_MAC = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_MAX = 4'd3;

    typedef enum logic [1:0] {
        PE_IDLE,
        PE_RUN,
        PE_DONE
    } pe_state_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RUN,
        L_WR,
        L_DONE
    } lane_state_e;

    // Any opcode outside MAC/ADD/MAX is a NOP and never starts the lanes.
    function automatic logic op_is_active(input logic [3:0] op);
        return (op == OP_MAC) || (op == OP_ADD) || (op == OP_MAX);
    endfunction

endpackage

// File: rtl/pe_stream_lane.sv
// rtl/pe_stream_lane.sv - one execution lane: stream accumulator, lane FSM and result write port
module pe_stream_lane
    import pe_array_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic              release_done,
    input  logic              lane_valid,
    input  logic              lane_eob,
    input  logic [DATA_W-1:0] lane_data0,
    input  logic [DATA_W-1:0] lane_data1,
    output logic              lane_ready,
    output logic              write_valid,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic              write_ready,
    output logic              done_next
);

    localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};

    lane_state_e       state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (start) begin
            state_d = L_RUN;
            acc_d   = (opcode == OP_MAX) ? MAX_INIT : '0;
        end else begin
            case (state_q)
                L_RUN: begin
                    if (lane_valid) begin
                        case (opcode)
                            OP_MAC:  acc_d = acc_q + lane_data0 * lane_data1;
                            OP_ADD:  acc_d = acc_q + lane_data0 + lane_data1;
                            OP_MAX:  if ($signed(lane_data0) > $signed(acc_q)) acc_d = lane_data0;
                            default: acc_d = acc_q;
                        endcase
                        if (lane_eob) state_d = L_WR;
                    end
                end
                L_WR:    if (write_ready) state_d = L_DONE;
                L_DONE:  if (release_done) state_d = L_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= L_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    assign lane_ready    = (state_q == L_RUN);
    assign write_valid   = (state_q == L_WR);
    assign write_address = address;
    assign write_data    = acc_q;
    // Lets the PE reach DONE on the edge that completes the last write.
    assign done_next     = (state_q == L_DONE) || ((state_q == L_WR) && write_ready);

endmodule

// File: rtl/pe_array.sv
// rtl/pe_array.sv - array of PEs, each a command FSM driving independent stream lanes
module pe_array
    import pe_array_pkg::*;
#(
    parameter int PE_ARRAY_NUM_OF_PE   = PE_ARRAY_NUM_OF_PE_DEF,
    parameter int PE_NUM_OF_EXEC_LANES = PE_NUM_OF_EXEC_LANES_DEF,
    parameter int DATA_W               = DATA_W_DEF,
    parameter int ADDR_W               = ADDR_W_DEF
) (
    input  logic                                                  clk,
    input  logic                                                  reset_poweron,
    input  logic [PE_ARRAY_NUM_OF_PE-1:0]                         sys__pe__oob_valid,
    input  logic [PE_ARRAY_NUM_OF_PE*4-1:0]                       sys__pe__oob_opcode,
    input  logic [PE_ARRAY_NUM_OF_PE*ADDR_W-1:0]                  sys__pe__oob_address,
    output logic [PE_ARRAY_NUM_OF_PE-1:0]                         pe__sys__oob_ready,
    input  logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES-1:0]        sys__pe__lane_valid,
    input  logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES-1:0]        sys__pe__lane_eob,
    input  logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES*DATA_W-1:0] sys__pe__lane_data0,
    input  logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES*DATA_W-1:0] sys__pe__lane_data1,
    output logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES-1:0]        pe__sys__lane_ready,
    output logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES-1:0]        dma__memc__write_valid,
    output logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES*ADDR_W-1:0] dma__memc__write_address,
    output logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES*DATA_W-1:0] dma__memc__write_data,
    input  logic [PE_ARRAY_NUM_OF_PE*PE_NUM_OF_EXEC_LANES-1:0]        memc__dma__write_ready,
    output logic [PE_ARRAY_NUM_OF_PE-1:0]                         pe__sys__complete
);

    localparam int NPE = PE_ARRAY_NUM_OF_PE;
    localparam int NL  = PE_NUM_OF_EXEC_LANES;

    for (genvar p = 0; p < NPE; p++) begin : g_pe
        pe_state_e         state_q, state_d;
        logic [3:0]        op_q, op_d;
        logic [ADDR_W-1:0] addr_q, addr_d;
        logic              start;
        logic              pe_done;
        logic [NL-1:0]     lane_done_next;

        always_comb begin
            state_d = state_q;
            op_d    = op_q;
            addr_d  = addr_q;
            start   = 1'b0;
            case (state_q)
                PE_IDLE: begin
                    if (sys__pe__oob_valid[p]) begin
                        op_d   = sys__pe__oob_opcode[p*4 +: 4];
                        addr_d = sys__pe__oob_address[p*ADDR_W +: ADDR_W];
                        if (op_is_active(op_d)) begin
                            state_d = PE_RUN;
                            start   = 1'b1;
                        end else begin
                            state_d = PE_DONE;
                        end
                    end
                end
                PE_RUN:  if (&lane_done_next) state_d = PE_DONE;
                PE_DONE: state_d = PE_IDLE;
                default: state_d = PE_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset_poweron) begin
            if (!reset_poweron) begin
                state_q <= PE_IDLE;
                op_q    <= '0;
                addr_q  <= '0;
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                addr_q  <= addr_d;
            end
        end

        assign pe_done               = (state_q == PE_DONE);
        assign pe__sys__oob_ready[p] = (state_q == PE_IDLE);
        assign pe__sys__complete[p]  = pe_done;

        for (genvar l = 0; l < NL; l++) begin : g_lane
            localparam int I = p*NL + l;
            // op_d equals op_q outside the accept cycle, so lanes see the new
            // opcode in time to pick the right accumulator start value.
            pe_stream_lane #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_lane (
                .clk           (clk),
                .reset_poweron (reset_poweron),
                .start         (start),
                .opcode        (op_d),
                .address       (addr_q),
                .release_done  (pe_done),
                .lane_valid    (sys__pe__lane_valid[I]),
                .lane_eob      (sys__pe__lane_eob[I]),
                .lane_data0    (sys__pe__lane_data0[I*DATA_W +: DATA_W]),
                .lane_data1    (sys__pe__lane_data1[I*DATA_W +: DATA_W]),
                .lane_ready    (pe__sys__lane_ready[I]),
                .write_valid   (dma__memc__write_valid[I]),
                .write_address (dma__memc__write_address[I*ADDR_W +: ADDR_W]),
                .write_data    (dma__memc__write_data[I*DATA_W +: DATA_W]),
                .write_ready   (memc__dma__write_ready[I]),
                .done_next     (lane_done_next[l])
            );
        end
    end

endmodule

// File: tb/tb_pe_array.sv
// tb/tb_pe_array.sv - self-checking bench for pe_array against a cycle-level behavioural model
module tb_pe_array;

    localparam int NPE = 4;
    localparam int NL  = 4;
    localparam int LN  = NPE * NL;
    localparam int DW  = 32;
    localparam int AW  = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NPE-1:0]    oob_valid;
    logic [NPE*4-1:0]  oob_opcode;
    logic [NPE*AW-1:0] oob_addr;
    logic [NPE-1:0]    oob_ready;
    logic [LN-1:0]     lane_valid, lane_eob, lane_ready;
    logic [LN*DW-1:0]  lane_d0, lane_d1;
    logic [LN-1:0]     wv, wr_ready;
    logic [LN*AW-1:0]  waddr;
    logic [LN*DW-1:0]  wdata;
    logic [NPE-1:0]    complete;

    pe_array #(
        .PE_ARRAY_NUM_OF_PE   (NPE),
        .PE_NUM_OF_EXEC_LANES (NL),
        .DATA_W               (DW),
        .ADDR_W               (AW)
    ) dut (
        .clk                      (clk),
        .reset_poweron            (rst_n),
        .sys__pe__oob_valid       (oob_valid),
        .sys__pe__oob_opcode      (oob_opcode),
        .sys__pe__oob_address     (oob_addr),
        .pe__sys__oob_ready       (oob_ready),
        .sys__pe__lane_valid      (lane_valid),
        .sys__pe__lane_eob        (lane_eob),
        .sys__pe__lane_data0      (lane_d0),
        .sys__pe__lane_data1      (lane_d1),
        .pe__sys__lane_ready      (lane_ready),
        .dma__memc__write_valid   (wv),
        .dma__memc__write_address (waddr),
        .dma__memc__write_data    (wdata),
        .memc__dma__write_ready   (wr_ready),
        .pe__sys__complete        (complete)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input bit ok, input string name, input int idx,
                                input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endfunction

    // Behavioural model: per-PE busy/pending-write bookkeeping and per-lane accumulators.
    bit          mbusy[NPE];
    bit          mcomp[NPE];
    logic [3:0]  mop[NPE];
    logic [AW-1:0] maddr[NPE];
    int          mpend[NPE];
    bit          mrun[LN];
    bit          mwr[LN];
    logic [DW-1:0] macc[LN];

    logic [DW-1:0] last_wdata[LN];
    logic [AW-1:0] last_waddr[LN];
    int obs_comp[NPE], obs_wr[NPE], comp_cyc[NPE], hs_cyc[NPE], stall_cnt[LN];
    int cyc = 0;
    bit rand_bp = 1'b0;

    logic [DW-1:0] s0[LN][8];
    logic [DW-1:0] s1[LN][8];
    int            slen[LN];

    function automatic logic [DW-1:0] model_op(input logic [3:0] op, input logic [DW-1:0] acc,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd1:    return acc + a * b;
            4'd2:    return acc + a + b;
            4'd3:    return ($signed(a) > $signed(acc)) ? a : acc;
            default: return acc;
        endcase
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NPE; p++) begin
            mbusy[p] = 0; mcomp[p] = 0; mpend[p] = 0;
        end
        for (int i = 0; i < LN; i++) begin
            mrun[i] = 0; mwr[i] = 0; macc[i] = '0;
        end
    endfunction

    function automatic void model_step();
        bit ncomp[NPE];
        int p;
        logic [3:0] op;
        for (int q = 0; q < NPE; q++) ncomp[q] = 0;
        for (int i = 0; i < LN; i++) begin
            p = i / NL;
            if (mwr[i] && !wr_ready[i]) stall_cnt[i]++;
            if (mrun[i] && lane_valid[i]) begin
                macc[i] = model_op(mop[p], macc[i], lane_d0[i*DW +: DW], lane_d1[i*DW +: DW]);
                if (lane_eob[i]) begin
                    mrun[i] = 0;
                    mwr[i]  = 1;
                end
            end else if (mwr[i] && wr_ready[i]) begin
                mwr[i] = 0;
                last_wdata[i] = macc[i];
                last_waddr[i] = maddr[p];
                mpend[p]--;
                if (mpend[p] == 0) ncomp[p] = 1;
            end
        end
        for (int q = 0; q < NPE; q++) begin
            if (mcomp[q]) begin
                mbusy[q] = 0;
            end else if (!mbusy[q] && oob_valid[q]) begin
                mbusy[q] = 1;
                op = oob_opcode[q*4 +: 4];
                if (op >= 4'd1 && op <= 4'd3) begin
                    mop[q]   = op;
                    maddr[q] = oob_addr[q*AW +: AW];
                    mpend[q] = NL;
                    for (int l = 0; l < NL; l++) begin
                        mrun[q*NL+l] = 1;
                        macc[q*NL+l] = (op == 4'd3) ? 32'h8000_0000 : 32'h0;
                    end
                end else begin
                    ncomp[q] = 1;
                end
            end
            mcomp[q] = ncomp[q];
        end
    endfunction

    always @(negedge clk) begin
        int p;
        cyc++;
        if (!rst_n) model_reset();
        for (int q = 0; q < NPE; q++) begin
            chk(complete[q] == mcomp[q], "complete", q, complete[q], mcomp[q]);
            chk(oob_ready[q] == !mbusy[q], "oob_ready", q, oob_ready[q], !mbusy[q]);
            if (complete[q]) begin
                obs_comp[q]++;
                comp_cyc[q] = cyc;
            end
        end
        for (int i = 0; i < LN; i++) begin
            p = i / NL;
            chk(lane_ready[i] == mrun[i], "lane_ready", i, lane_ready[i], mrun[i]);
            chk(wv[i] == mwr[i], "write_valid", i, wv[i], mwr[i]);
            if (mwr[i]) begin
                chk(waddr[i*AW +: AW] == maddr[p], "write_address", i, waddr[i*AW +: AW], maddr[p]);
                chk(wdata[i*DW +: DW] == macc[i], "write_data", i, wdata[i*DW +: DW], macc[i]);
            end
            if (wv[i] && wr_ready[i]) begin
                obs_wr[p]++;
                hs_cyc[p] = cyc;
            end
        end
        if (rst_n) model_step();
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_bp) wr_ready = LN'($urandom);
    end

    task automatic issue_cmd(input int p, input logic [3:0] op, input logic [AW-1:0] a);
        int n = 0;
        oob_valid[p] = 1'b1;
        oob_opcode[p*4 +: 4] = op;
        oob_addr[p*AW +: AW] = a;
        do begin
            @(negedge clk);
            n++;
        end while (!oob_ready[p] && n < 300);
        if (!oob_ready[p]) chk(0, "cmd_accept_timeout", p, 0, 1);
        @(posedge clk); #1;
        oob_valid[p] = 1'b0;
    endtask

    task automatic drive_lane(input int i, input bit gap);
        int  n;
        bit  took;
        for (int e = 0; e < slen[i]; e++) begin
            if (gap && $urandom_range(0, 1) == 1) begin
                lane_valid[i] = 1'b0;
                @(posedge clk); #1;
            end
            lane_valid[i] = 1'b1;
            lane_eob[i]   = (e == slen[i] - 1);
            lane_d0[i*DW +: DW] = s0[i][e];
            lane_d1[i*DW +: DW] = s1[i][e];
            n = 0;
            took = 0;
            while (!took && n < 300) begin
                @(negedge clk);
                took = lane_ready[i];
                @(posedge clk); #1;
                n++;
            end
            if (!took) begin
                chk(0, "lane_accept_timeout", i, 0, 1);
                break;
            end
        end
        lane_valid[i] = 1'b0;
        lane_eob[i]   = 1'b0;
    endtask

    task automatic run_pe(input int p, input logic [3:0] op, input logic [AW-1:0] a, input bit gap);
        fork
            issue_cmd(p, op, a);
        join_none
        for (int l = 0; l < NL; l++) begin
            automatic int li = p*NL + l;
            fork
                drive_lane(li, gap);
            join_none
        end
        wait fork;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit idle = 0;
        while (!idle && n < 500) begin
            @(negedge clk); #1;
            n++;
            idle = 1;
            for (int p = 0; p < NPE; p++) if (mbusy[p]) idle = 0;
        end
        chk(idle, "idle_timeout", 0, idle, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_stream(input int i, input int len);
        slen[i] = len;
    endtask

    initial begin
        int c0, w0, wtot;
        logic [DW-1:0] e0;

        oob_valid = '0; oob_opcode = '0; oob_addr = '0;
        lane_valid = '0; lane_eob = '0; lane_d0 = '0; lane_d1 = '0;
        wr_ready = '1;
        #60000000 ;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, wtot;
        logic [DW-1:0] e0;

        #1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk); #1;
        chk(oob_ready == 4'hF, "rst_oob_ready", 0, oob_ready, 4'hF);
        chk(lane_ready == '0, "rst_lane_ready", 0, lane_ready, 0);
        chk(wv == '0, "rst_write_valid", 0, wv, 0);
        chk(complete == '0, "rst_complete", 0, complete, 0);
        @(posedge clk); #1;

        // MAC on PE0: lane0 {1,2,3}x{4,5,6} = 32, other lanes 2*3 = 6
        slen[0] = 3;
        s0[0][0] = 1; s0[0][1] = 2; s0[0][2] = 3;
        s1[0][0] = 4; s1[0][1] = 5; s1[0][2] = 6;
        for (int l = 1; l < NL; l++) begin
            slen[l] = 1; s0[l][0] = 2; s1[l][0] = 3;
        end
        run_pe(0, 4'd1, 16'h0010, 1'b0);
        wait_idle();
        chk(last_wdata[0] == 32, "mac_lane0_data", 0, last_wdata[0], 32);
        chk(last_waddr[0] == 16'h0010, "mac_lane0_addr", 0, last_waddr[0], 16'h0010);
        chk(last_wdata[1] == 6, "mac_lane1_data", 1, last_wdata[1], 6);
        chk(obs_comp[0] == 1, "mac_complete_count", 0, obs_comp[0], 1);
        chk(comp_cyc[0] - hs_cyc[0] == 1, "mac_complete_latency", 0, comp_cyc[0] - hs_cyc[0], 1);

        // MAX on PE1: {-5,7,3} -> 7; single -9 -> -9
        slen[4] = 3;
        s0[4][0] = -32'sd5; s0[4][1] = 7; s0[4][2] = 3;
        s1[4][0] = 0; s1[4][1] = 0; s1[4][2] = 0;
        for (int l = 5; l < 8; l++) begin
            slen[l] = 1; s0[l][0] = -32'sd9; s1[l][0] = 0;
        end
        run_pe(1, 4'd3, 16'h0020, 1'b0);
        wait_idle();
        chk(last_wdata[4] == 7, "max_data", 4, last_wdata[4], 7);
        chk(last_wdata[5] == 32'hFFFF_FFF7, "max_single_neg", 5, last_wdata[5], 32'hFFFF_FFF7);

        // ADD on PE2: 0xFFFFFFFF + 2 wraps to 1
        for (int l = 8; l < 12; l++) begin
            slen[l] = 1; s0[l][0] = 32'hFFFF_FFFF; s1[l][0] = 2;
        end
        run_pe(2, 4'd2, 16'h0030, 1'b0);
        wait_idle();
        chk(last_wdata[8] == 1, "add_wrap", 8, last_wdata[8], 1);
        chk(last_waddr[11] == 16'h0030, "add_addr", 11, last_waddr[11], 16'h0030);

        // Backpressure on PE3 lane 12 for 5 cycles; command on PE3 while busy is held off
        for (int l = 12; l < 16; l++) begin
            slen[l] = 1; s0[l][0] = 3; s1[l][0] = 4;
        end
        wr_ready[12] = 1'b0;
        stall_cnt[12] = 0;
        c0 = obs_comp[3];
        fork
            run_pe(3, 4'd1, 16'h0040, 1'b0);
        join_none
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wv[12] && n < 100);
            chk(wv[12], "stall_wait_timeout", 12, wv[12], 1);
            oob_valid[3] = 1'b1;
            oob_opcode[12 +: 4] = 4'd2;
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
            oob_valid[3] = 1'b0;
            wr_ready[12] = 1'b1;
        end
        wait fork;
        wait_idle();
        chk(stall_cnt[12] == 5, "stall_cycles", 12, stall_cnt[12], 5);
        chk(last_wdata[12] == 12, "stall_data", 12, last_wdata[12], 12);
        chk(obs_comp[3] == c0 + 1, "stall_complete_count", 3, obs_comp[3], c0 + 1);
        chk(comp_cyc[3] - hs_cyc[3] == 1, "stall_complete_latency", 3, comp_cyc[3] - hs_cyc[3], 1);

        // Opcode 9 on PE0 is a NOP: one complete pulse, no writes
        c0 = obs_comp[0];
        w0 = obs_wr[0];
        issue_cmd(0, 4'd9, 16'h0055);
        wait_idle();
        chk(obs_comp[0] == c0 + 1, "nop_complete", 0, obs_comp[0], c0 + 1);
        chk(obs_wr[0] == w0, "nop_no_writes", 0, obs_wr[0], w0);

        // Reset mid-stream on PE1, then a normal command afterwards
        issue_cmd(1, 4'd1, 16'h0060);
        lane_valid[4] = 1'b1; lane_eob[4] = 1'b0;
        lane_d0[4*DW +: DW] = 5; lane_d1[4*DW +: DW] = 5;
        @(posedge clk); #1;
        lane_valid[4] = 1'b0;
        chk(lane_ready[5], "pre_reset_lane_ready", 5, lane_ready[5], 1);
        #1 rst_n = 1'b0;
        #1;
        chk(wv == '0, "async_rst_write_valid", 0, wv, 0);
        chk(lane_ready == '0, "async_rst_lane_ready", 0, lane_ready, 0);
        chk(complete == '0, "async_rst_complete", 0, complete, 0);
        chk(oob_ready == 4'hF, "async_rst_oob_ready", 0, oob_ready, 4'hF);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int l = 4; l < 8; l++) begin
            slen[l] = 1; s0[l][0] = 6; s1[l][0] = 7;
        end
        run_pe(1, 4'd1, 16'h0070, 1'b0);
        wait_idle();
        chk(last_wdata[4] == 42, "post_reset_data", 4, last_wdata[4], 42);
        chk(last_waddr[4] == 16'h0070, "post_reset_addr", 4, last_waddr[4], 16'h0070);

        // All PEs concurrently, random-length MAC streams with gaps and random write_ready
        for (int i = 0; i < LN; i++) begin
            slen[i] = $urandom_range(1, 6);
            for (int e = 0; e < 8; e++) begin
                s0[i][e] = $urandom;
                s1[i][e] = $urandom;
            end
        end
        e0 = '0;
        for (int e = 0; e < slen[0]; e++) e0 = e0 + s0[0][e] * s1[0][e];
        wtot = 0;
        for (int p = 0; p < NPE; p++) wtot += obs_wr[p];
        rand_bp = 1'b1;
        for (int p = 0; p < NPE; p++) begin
            automatic int pp = p;
            fork
                run_pe(pp, 4'd1, AW'(16'h0100 + pp), 1'b1);
            join_none
        end
        wait fork;
        @(posedge clk); #2;
        rand_bp = 1'b0;
        wr_ready = '1;
        wait_idle();
        c0 = 0;
        for (int p = 0; p < NPE; p++) c0 += obs_wr[p];
        chk(c0 - wtot == LN, "rand_write_count", 0, c0 - wtot, LN);
        chk(last_wdata[0] == e0, "rand_lane0_sum", 0, last_wdata[0], e0);
        chk(last_waddr[15] == 16'h0103, "rand_lane15_addr", 15, last_waddr[15], 16'h0103);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_array.md
PE_ARRAY -- requirements
Module: pe_array

Interface
REQ-001 SHALL have parameter PE_ARRAY_NUM_OF_PE, default 4: number of PEs.
REQ-002 SHALL have parameter PE_NUM_OF_EXEC_LANES, default 4: lanes per PE.
REQ-003 SHALL have parameter DATA_W, default 32: lane operand and result width.
REQ-004 SHALL have parameter ADDR_W, default 16: result memory word address width.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset_poweron, input, 1: reset; asynchronous, active-low.
REQ-007 SHALL have port sys__pe__oob_valid, input, [NPE]: command valid per PE.
REQ-008 SHALL have port sys__pe__oob_opcode, input, [NPE][3:0]: operation.
REQ-009 SHALL have port sys__pe__oob_address, input, [NPE][ADDR_W]: result address.
REQ-010 SHALL have port pe__sys__oob_ready, output, [NPE]: PE idle, command accepted.
REQ-011 SHALL have port sys__pe__lane_valid, input, [NPE][NL]: stream element valid.
REQ-012 SHALL have port sys__pe__lane_eob, input, [NPE][NL]: last element of stream.
REQ-013 SHALL have ports sys__pe__lane_data0 and sys__pe__lane_data1, input, [NPE][NL][DATA_W]: operands.
REQ-014 SHALL have port pe__sys__lane_ready, output, [NPE][NL]: lane accepts element.
REQ-015 SHALL have ports dma__memc__write_valid [NPE][NL], write_address [NPE][NL][ADDR_W] and write_data [NPE][NL][DATA_W], output: result write.
REQ-016 SHALL have port memc__dma__write_ready, input, [NPE][NL]: memory accepts write.
REQ-017 SHALL have port pe__sys__complete, output, [NPE]: one-cycle done pulse.

Function
REQ-018 Command handshake SHALL fire on oob_valid&oob_ready; ready = PE state IDLE; capture opcode/address.
REQ-019 PE FSM SHALL be IDLE -> RUN (on accept) -> DONE (all lanes written) -> IDLE; complete=1 only in DONE (exactly one cycle).
REQ-020 Opcode 1 MAC: acc += data0*data1, low DATA_W bits, wraps.
REQ-021 Opcode 2 ADD: acc += data0+data1, wraps.
REQ-022 Opcode 3 MAX: acc = signed max(acc, data0); acc initialised 0x8000_0000.
REQ-023 Opcode 0 and 4-15 SHALL be NOP: no lane activity, no writes; IDLE -> DONE -> IDLE.
REQ-024 On accept, every lane acc SHALL clear to 0 (MAC/ADD) and lane FSM go L_RUN.
REQ-025 Lane FSM: L_IDLE, L_RUN, L_WR, L_DONE; lane_ready=1 only in L_RUN.
REQ-026 Element accepted on lane_valid&lane_ready, acc updated next edge; element with eob=1 -> L_WR.
REQ-027 L_WR: write_valid=1 with address=captured address, data=final acc (incl. the eob element), held stable until write_ready; then L_DONE.
REQ-028 Latency: write_valid rises the cycle after the eob element is accepted; complete pulses the cycle after the last lane's write handshake.
REQ-029 Single element with eob=1 SHALL be a valid stream.
REQ-030 Stream input while lane not in L_RUN SHALL be ignored; oob_valid while busy SHALL be held off.
REQ-031 PEs and lanes SHALL be fully independent; lanes may finish in any order.

Reset
REQ-032 Reset asserted SHALL force all FSMs to IDLE/L_IDLE, acc=0, write_valid=0, complete=0, lane_ready=0, oob_ready=1, regardless of any operation in progress (in-flight results discarded).

Structure
REQ-033 Package pe_array_pkg SHALL hold parameter defaults, opcode constants and both FSM state enums.
REQ-034 Sub-module pe_stream_lane SHALL implement one lane (acc, lane FSM, write port); pe_array generates PE control plus NL lane instances per PE.

Verification
REQ-035 MAC on PE0 lane0, data0={1,2,3}, data1={4,5,6}, address 0x10 -> write 0x10 data 32; complete pulse one cycle after the last lane write.
REQ-036 MAX data0={-5,7,3}, one element, eob on third -> write 7; ADD single element 0xFFFF_FFFF+2 -> 1 (wrap).
REQ-037 write_ready held low 5 cycles -> write_valid/address/data stable 5 cycles, complete only after handshake.
REQ-038 Opcode 9 -> no lane ready, no writes, complete pulse; oob_ready returns high next cycle.
REQ-039 Reset asserted mid-stream -> all outputs at reset values immediately; new command after release behaves normally.
REQ-040 All PEs/lanes concurrent random-length MAC streams -> each write matches the software model.
